// File: rtl/serial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : serial_accumulator
// Purpose  : Bit-serial add/subtract stage. An LSB-first operand stream is
//            added into, or subtracted from, a circulating WIDTH-bit
//            two's-complement accumulator, one bit per clock. Sum bits enter
//            at the MSB, so the register is realigned after WIDTH cycles.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            word_start - strobe coincident with operand bit 0
//            in_bit     - serial operand, LSB first
//            op[1:0]    - 00 hold, 01 add, 10 subtract, 11 clear
//            acc_bit    - accumulator bit consumed this cycle (acc[0])
//            acc_word   - parallel accumulator (valid while idle)
//            word_done  - one-cycle pulse after the last bit is written
//            overflow   - sticky two's-complement overflow
//            frame_err  - sticky, word_start seen while busy
// Config   : SERIAL_ACC_OVERFLOW_EN - define to build overflow detection;
//            when undefined, overflow is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module serial_accumulator #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_start,
    input  logic             in_bit,
    input  logic [1:0]       op,
    output logic             acc_bit,
    output logic [WIDTH-1:0] acc_word,
    output logic             word_done,
    output logic             overflow,
    output logic             frame_err
);

    // Counter is always 6 bits wide: enough for WIDTH up to 64.
    localparam int              CNT_W      = 6;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             cy_q,    cy_d;
    logic [1:0]       op_q,    op_d;
    logic             done_q,  done_d;
    logic             ferr_q,  ferr_d;

    // ------------------------------------------------------------------
    // Serial datapath: two half-adder cells with a delayed carry
    // ------------------------------------------------------------------
    logic       w_accept;   // word_start taken in IDLE: bit 0 this cycle
    logic       w_last;     // processing bit WIDTH-1 this cycle
    logic [1:0] w_op;       // op in force for the bit being processed
    logic       w_a;
    logic       w_b;
    logic       w_cin;
    logic       w_sum;
    logic       w_cout;
    logic       w_arith;    // add or subtract in force

    assign w_accept = (state_q == S_IDLE) && word_start;
    assign w_last   = (state_q == S_RUN) && (cnt_q == C_LAST_CNT);

    // Bit 0 uses the op port directly; later bits use the latched copy.
    assign w_op    = (state_q == S_IDLE) ? op : op_q;
    assign w_arith = (w_op == OP_ADD) || (w_op == OP_SUB);
    assign w_a     = acc_q[0];

    always_comb begin
        w_b = 1'b0;
        if (w_op == OP_ADD) begin
            w_b = in_bit;
        end else if (w_op == OP_SUB) begin
            w_b = ~in_bit;
        end
    end

    // Subtract is a + ~b + 1: the +1 enters as the carry into bit 0.
    assign w_cin  = (state_q == S_IDLE) ? (w_op == OP_SUB) : cy_q;
    assign w_sum  = (w_op == OP_CLEAR) ? 1'b0 : (w_a ^ w_b ^ w_cin);
    assign w_cout = (w_a & w_b) | (w_a & w_cin) | (w_b & w_cin);

    // ------------------------------------------------------------------
    // Control: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        op_d    = op_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (word_start) begin
                    acc_d   = {w_sum, acc_q[WIDTH-1:1]};
                    cy_d    = w_cout;
                    op_d    = op;
                    cnt_d   = CNT_W'(1);
                    state_d = S_RUN;
                    if (op == OP_CLEAR) begin
                        ferr_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                acc_d = {w_sum, acc_q[WIDTH-1:1]};
                // A strobe mid-word is flagged but does not disturb the word.
                if (word_start) begin
                    ferr_d = 1'b1;
                end
                if (w_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    cy_d  = w_cout;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                cy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            op_q    <= OP_HOLD;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            op_q    <= op_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Overflow: carry into the sign bit differs from carry out of it
    // ------------------------------------------------------------------
`ifdef SERIAL_ACC_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (w_accept && (op == OP_CLEAR)) begin
            ovf_d = 1'b0;
        end else if (w_last && w_arith) begin
            ovf_d = ovf_q | (w_cin ^ w_cout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign acc_bit   = acc_q[0];
    assign acc_word  = acc_q;
    assign word_done = done_q;
    assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_accumulator
// Purpose  : Self-checking bench for serial_accumulator (WIDTH=35). Expected
//            values come from a word-level arithmetic model of the
//            accumulator and its sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_accumulator;

    localparam int W = 35;

`ifdef SERIAL_ACC_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         word_start;
    logic         in_bit;
    logic [1:0]   op;
    logic         acc_bit;
    logic [W-1:0] acc_word;
    logic         word_done;
    logic         overflow;
    logic         frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Word-level reference state
    logic [W-1:0] m_acc;
    logic         m_ovf;
    logic         m_ferr;

    serial_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_start (word_start),
        .in_bit     (in_bit),
        .op         (op),
        .acc_bit    (acc_bit),
        .acc_word   (acc_word),
        .word_done  (word_done),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf"},  W'(overflow),  W'(OVF_EN ? m_ovf : 1'b0));
        check({tag, "_ferr"}, W'(frame_err), W'(m_ferr));
    endtask

    // One word. b2b: start in the current cycle (no idle gap).
    // ferr_at / rst_at: bit index at which a stray strobe / reset is applied (-1 = none).
    task automatic run_word(input string tag, input logic [1:0] o, input logic [W-1:0] v,
                            input bit b2b, input int ferr_at, input int rst_at);
        logic [W-1:0] pre;
        logic [W-1:0] res;
        logic         ovf_new;
        pre     = m_acc;
        res     = m_acc;
        ovf_new = 1'b0;
        case (o)
            OP_ADD: begin
                res     = m_acc + v;
                ovf_new = (m_acc[W-1] == v[W-1]) && (res[W-1] != m_acc[W-1]);
            end
            OP_SUB: begin
                res     = m_acc - v;
                ovf_new = (m_acc[W-1] != v[W-1]) && (res[W-1] != m_acc[W-1]);
            end
            OP_CLEAR: res = '0;
            default:  res = m_acc;
        endcase

        for (int i = 0; i < W; i++) begin
            if (i > 0 || !b2b) @(negedge clk);
            check({tag, "_acc_bit"}, W'(acc_bit), W'(pre[i]));
            if (i > 0) check({tag, "_early_done"}, W'(word_done), '0);
            word_start = (i == 0) || (i == ferr_at);
            op         = (i == 0) ? o : 2'($urandom);
            in_bit     = v[i];
            rst        = (i == rst_at);
            if (i == rst_at) begin
                @(negedge clk);
                rst        = 1'b0;
                word_start = 1'b0;
                m_acc  = '0;
                m_ovf  = 1'b0;
                m_ferr = 1'b0;
                check({tag, "_rst_acc"},  acc_word, '0);
                check({tag, "_rst_done"}, W'(word_done), '0);
                check_flags({tag, "_rst"});
                for (int k = 0; k < W + 2; k++) begin
                    @(negedge clk);
                    check({tag, "_rst_nodone"}, W'(word_done), '0);
                end
                return;
            end
        end

        @(negedge clk);
        word_start = 1'b0;
        if (o == OP_CLEAR) begin
            m_ovf  = 1'b0;
            m_ferr = 1'b0;
        end
        m_acc = res;
        m_ovf = m_ovf | ovf_new;
        if (ferr_at > 0) m_ferr = 1'b1;
        check({tag, "_done"}, W'(word_done), W'(1));
        check({tag, "_acc"},  acc_word, m_acc);
        check_flags(tag);
    endtask

    initial begin
        logic [63:0]  r64;
        logic [1:0]   rop;

        // Reset held two cycles, with a competing strobe that must lose.
        rst        = 1'b1;
        word_start = 1'b1;
        op         = OP_ADD;
        in_bit     = 1'b1;
        m_acc      = '0;
        m_ovf      = 1'b0;
        m_ferr     = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset_done", W'(word_done), '0);
        end
        check("reset_acc", acc_word, '0);
        check("reset_acc_bit", W'(acc_bit), '0);
        check_flags("reset");
        rst        = 1'b0;
        word_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_done", W'(word_done), '0);
            check("idle_acc", acc_word, '0);
        end

        // Clear, add 5, add 7, back to back
        run_word("clear0", OP_CLEAR, W'($urandom), 1'b0, -1, -1);
        run_word("add5",   OP_ADD,   W'(5),        1'b1, -1, -1);
        run_word("add7",   OP_ADD,   W'(7),        1'b1, -1, -1);
        check("twelve", acc_word, W'(12));

        // Subtract 20 from 12 -> -8, then hold
        run_word("sub20", OP_SUB, W'(20), 1'b1, -1, -1);
        check("minus8", acc_word, 35'h7_FFFF_FFF8);
        run_word("hold", OP_HOLD, W'($urandom), 1'b0, -1, -1);
        check("hold_val", acc_word, 35'h7_FFFF_FFF8);

        // Overflow: max positive + 1
        run_word("clear1",  OP_CLEAR, W'(0),            1'b0, -1, -1);
        run_word("addmax",  OP_ADD,   35'h3_FFFF_FFFF,  1'b1, -1, -1);
        run_word("addone",  OP_ADD,   W'(1),            1'b1, -1, -1);
        check("max_plus_one", acc_word, 35'h4_0000_0000);
        check("ovf_set", W'(overflow), W'(OVF_EN));
        run_word("clear2", OP_CLEAR, W'(0), 1'b1, -1, -1);
        check("ovf_cleared", W'(overflow), '0);

        // Stray strobe mid-word
        run_word("add3", OP_ADD, W'(3), 1'b0, 10, -1);
        check("ferr_result", acc_word, W'(3));
        check("ferr_set", W'(frame_err), W'(1));

        // Reset mid-word, then recover
        run_word("clear3", OP_CLEAR, W'(0), 1'b0, -1, -1);
        run_word("add4",   OP_ADD,   W'(4), 1'b1, -1, -1);
        run_word("add9r",  OP_ADD,   W'(9), 1'b1, -1, 10);
        run_word("add1",   OP_ADD,   W'(1), 1'b0, -1, -1);
        check("after_rst", acc_word, W'(1));

        // Randomized words
        for (int n = 0; n < 24; n++) begin
            r64 = {$urandom, $urandom};
            rop = 2'($urandom);
            if (rop == OP_CLEAR && ($urandom % 3) != 0) rop = OP_ADD;
            run_word("rand", rop, W'(r64), 1'($urandom), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_accumulator.md
# serial_accumulator

Bit-serial accumulator stage for the EDSAC arithmetic unit. It takes an LSB-first operand stream, one bit per `clk`, and adds or subtracts it into a circulating WIDTH-bit two's-complement accumulator. The adder is two half-adder cells plus a one-clock delayed carry, and the carry is cleared at every word boundary. Sum bits re-enter the accumulator MSB, so after WIDTH cycles the register is realigned.

## Interface
Parameters:
- `WIDTH`, 35, word length in bits (long word); legal range 4..64.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `word_start`  in  1  one-cycle strobe coincident with operand bit 0 on `in_bit`.
- `in_bit`  in  1  serial operand, LSB first.
- `op`  in  2  sampled only with accepted `word_start`: 00 hold, 01 add, 10 subtract, 11 clear.
- `acc_bit`  out  1  `acc[0]`: the pre-operation accumulator bit being consumed this cycle.
- `acc_word`  out  WIDTH  parallel accumulator contents.
- `word_done`  out  1  one-cycle pulse after the last bit is written.
- `overflow`  out  1  sticky two's-complement overflow.
- `frame_err`  out  1  sticky; set by `word_start` while busy.

## Operation
- States: IDLE and RUN; 6-bit-safe bit counter `cnt` (0..WIDTH-1); carry flop `cy`; latched op `op_q`.
- IDLE: `acc` is frozen. An accepted `word_start` processes bit 0 in the same cycle, using `op` directly. It latches `op_q`, sets `cnt` to 1 and enters RUN.
  - If WIDTH-1 == 0 the block returns to IDLE; this cannot occur in the legal range.
- Per processed bit:
  - a = `acc[0]`.
  - b = `in_bit` for add, `~in_bit` for subtract, 0 for hold and clear.
  - carry-in = `cy`, forced to 1 on bit 0 for subtract and to 0 on bit 0 otherwise.
  - s = a^b^cin; `cy` <= majority(a,b,cin).
  - `acc` <= {s, acc[WIDTH-1:1]}. For clear, s is forced to 0.
- Hold rotates `acc` unchanged through the adder, so the contents are preserved.
- RUN increments `cnt` per cycle. After processing bit WIDTH-1 it returns to IDLE, pulses `word_done` next cycle and clears `cy`.
- `word_start` in RUN: ignored, `frame_err` <= 1, current word unaffected.
- Overflow at bit WIDTH-1: `overflow` <= `overflow` | (cin ^ cout) for add/subtract.
  - Clear op clears `overflow` and `frame_err`.
- `acc_word` is only meaningful when IDLE; mid-word it is partially rotated.

## Timing
- Reset values:
  - `acc`=0, `cy`=0, `cnt`=0, state IDLE.
  - `acc_bit`=0, `acc_word`=0, `word_done`=0, `overflow`=0, `frame_err`=0.
- `word_start` at cycle T processes bits at T..T+WIDTH-1. `word_done`=1 at T+WIDTH, when `acc_word` holds the result.
- Back-to-back: `word_start` at T+WIDTH is accepted; there are no bubbles.
- `rst` beats every other input in the same cycle.
  - `rst` mid-word abandons the word: `acc`=0, IDLE, no `word_done`.
- `in_bit` and `op` are don't-care when not processing.
- Wrap-around: results are modulo 2^WIDTH; carry out of bit WIDTH-1 is discarded except for overflow.

## Configuration
- `SERIAL_ACC_OVERFLOW_EN`: when defined, overflow detection is built as above.
  - When undefined, `overflow` is tied to 0 and the cin/cout compare logic is omitted.
  - Arithmetic results are identical in both builds.

## Test plan
All cases use WIDTH=35.
- Reset: hold `rst` 2 cycles -> `acc_word`=0, all flags 0, `word_done` never pulses.
- Clear, then add 5, then add 7 -> `acc_word`=12. Each `word_done` comes exactly 35 cycles after its `word_start`. Back-to-back words show no gaps.
- From 12, subtract 20 -> `acc_word`=2^35-8 (-8), `overflow`=0; then hold -> value unchanged, `acc_bit` streams the same bits.
- Clear, add 2^34-1, add 1 -> `acc_word`=2^34 and `overflow`=1 (0 if macro undefined). Clear -> `overflow`=0.
- Add 3 from 0; pulse `word_start` at bit 10 -> `frame_err`=1, result 3, `word_done` still at T+35.
- Start add 9 from value 4; assert `rst` at bit 10 -> `acc_word`=0, IDLE, no `word_done`; next add 1 yields 1.
